// File: rtl/id_pipe.sv
// Buffered instruction decoder: splits each accepted word into opcode, memory-op and operand
// fields and queues them in a DEPTH-entry FIFO. Illegal-opcode flagging under ID_ILLEGAL_CHECK_EN.
module id_pipe #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned OP_W = 4,
    parameter int unsigned MEM_W = 4,
    parameter int unsigned OPND_W = 8,
    parameter int unsigned DEPTH = 2,
    parameter logic [(2**OP_W)-1:0] LEGAL_MASK = '1
) (
    input  logic                         CLK,
    input  logic                         RST_N,
    input  logic                         ID_CE,
    input  logic                         FLUSH,
    input  logic                         IN_VALID,
    output logic                         IN_READY,
    input  logic [INSTR_W-1:0]           INSTR,
    output logic                         OUT_VALID,
    input  logic                         OUT_READY,
    output logic [OP_W-1:0]              OP_CODE,
    output logic [MEM_W-1:0]             MEM_OP,
    output logic [OPND_W-1:0]            OPERAND,
    output logic [OPND_W/2-1:0]          LEFT_OPERAND,
    output logic [OPND_W/2-1:0]          RIGHT_OPERAND,
    output logic                         ILLEGAL,
    output logic                         ILLEGAL_STICKY,
    output logic [$clog2(DEPTH+1)-1:0]   OCCUPANCY
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_occ;

    logic [OP_W-1:0]   r_op_mem   [DEPTH];
    logic [MEM_W-1:0]  r_memop_mem[DEPTH];
    logic [OPND_W-1:0] r_opnd_mem [DEPTH];

    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic [OP_W-1:0]   w_in_op;
    logic [MEM_W-1:0]  w_in_mem;
    logic [OPND_W-1:0] w_in_opnd;

    assign w_in_op   = INSTR[INSTR_W-1 -: OP_W];
    assign w_in_mem  = INSTR[INSTR_W-OP_W-1 -: MEM_W];
    assign w_in_opnd = INSTR[OPND_W-1:0];

    assign w_empty   = (r_occ == '0);
    // RST_N gating keeps IN_READY low for the whole time reset is held.
    assign IN_READY  = RST_N && ID_CE && !FLUSH && (r_occ < CNT_W'(DEPTH));
    assign OUT_VALID = ID_CE && !w_empty;
    assign w_push    = IN_VALID && IN_READY;
    assign w_pop     = OUT_VALID && OUT_READY && !FLUSH;
    assign OCCUPANCY = r_occ;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (ID_CE) begin
            if (FLUSH) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_occ    <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_push, w_pop})
                    2'b10:   r_occ <= r_occ + CNT_W'(1);
                    2'b01:   r_occ <= r_occ - CNT_W'(1);
                    default: r_occ <= r_occ;
                endcase
            end
        end
    end

    // Payload storage needs no reset: the empty-masking below hides stale entries.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr]    <= w_in_op;
            r_memop_mem[r_wr_ptr] <= w_in_mem;
            r_opnd_mem[r_wr_ptr]  <= w_in_opnd;
        end
    end

    always_comb begin
        OP_CODE = '0;
        MEM_OP  = '0;
        OPERAND = '0;
        if (!w_empty) begin
            OP_CODE = r_op_mem[r_rd_ptr];
            MEM_OP  = r_memop_mem[r_rd_ptr];
            OPERAND = r_opnd_mem[r_rd_ptr];
        end
    end

    assign LEFT_OPERAND  = OPERAND[OPND_W-1 -: OPND_W/2];
    assign RIGHT_OPERAND = OPERAND[OPND_W/2-1:0];

`ifdef ID_ILLEGAL_CHECK_EN
    logic r_ill_mem [DEPTH];
    logic r_sticky;
    logic w_in_ill;

    assign w_in_ill = ~LEGAL_MASK[w_in_op];

    always_ff @(posedge CLK) begin
        if (w_push) r_ill_mem[r_wr_ptr] <= w_in_ill;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sticky <= 1'b0;
        end else if (ID_CE) begin
            if (FLUSH) r_sticky <= 1'b0;
            else if (w_push && w_in_ill) r_sticky <= 1'b1;
        end
    end

    assign ILLEGAL        = !w_empty && r_ill_mem[r_rd_ptr];
    assign ILLEGAL_STICKY = r_sticky;
`else
    logic w_unused_mask;
    assign w_unused_mask  = ^LEGAL_MASK;
    assign ILLEGAL        = 1'b0;
    assign ILLEGAL_STICKY = 1'b0;
`endif

endmodule
